// File: rtl/ahb2_cmd_master.sv
// AHB2 (AHB-Lite) single-word initiator: turns a valid/ready command stream into
// pipelined NONSEQ/SINGLE word transfers and returns one response per command.
module ahb2_cmd_master #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_write,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  idle,
    output logic [ADDR_WIDTH-1:0] haddr,
    output logic [1:0]            htrans,
    output logic                  hwrite,
    output logic [2:0]            hsize,
    output logic [2:0]            hburst,
    output logic [3:0]            hprot,
    output logic [31:0]           hwdata,
    input  logic [31:0]           hrdata,
    input  logic                  hready,
    input  logic                  hresp
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] aligned;
        aligned       = addr;
        aligned[1:0]  = 2'b00;
        return aligned;
    endfunction

    logic                  ap_valid_r;
    logic [ADDR_WIDTH-1:0] ap_addr_r;
    logic                  ap_write_r;
    logic [31:0]           ap_wdata_r;
    logic                  dp_valid_r;
    logic                  dp_write_r;
    logic [31:0]           dp_wdata_r;
    logic                  err_hold_r;
    logic                  rsp_valid_r;
    logic                  rsp_write_r;
    logic [31:0]           rsp_rdata_r;
    logic                  rsp_err_r;

    logic                  advance_s;
    logic                  cmd_ready_s;
    logic                  accept_s;
    logic                  dp_done_s;
    logic                  err_first_s;
    logic                  err_second_s;

    // Pipeline control: when the address phase may move on and whether a command is taken.
    always_comb begin
        advance_s    = hready & ~err_hold_r;
        cmd_ready_s  = ~ap_valid_r | advance_s;
        accept_s     = cmd_valid & cmd_ready_s;
        dp_done_s    = dp_valid_r & hready;
        err_first_s  = dp_valid_r & hresp & ~hready & ~err_hold_r;
        err_second_s = err_hold_r & hready;
    end

    // Address-phase register: loads on accept, empties when it advances with nothing behind it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ap_valid_r <= 1'b0;
            ap_addr_r  <= '0;
            ap_write_r <= 1'b0;
            ap_wdata_r <= 32'h0000_0000;
        end else if (accept_s) begin
            ap_valid_r <= 1'b1;
            ap_addr_r  <= word_align(cmd_addr);
            ap_write_r <= cmd_write;
            ap_wdata_r <= cmd_wdata;
        end else if (advance_s) begin
            ap_valid_r <= 1'b0;
        end else begin
            ap_valid_r <= ap_valid_r;
        end
    end

    // Data-phase register: takes the address phase on advance; an ERROR completion just retires it.
    always_ff @(posedge clk) begin
        if (rst) begin
            dp_valid_r <= 1'b0;
            dp_write_r <= 1'b0;
            dp_wdata_r <= 32'h0000_0000;
        end else if (advance_s) begin
            dp_valid_r <= ap_valid_r;
            if (ap_valid_r) begin
                dp_write_r <= ap_write_r;
                dp_wdata_r <= ap_wdata_r;
            end
        end else if (dp_done_s) begin
            dp_valid_r <= 1'b0;
        end else begin
            dp_valid_r <= dp_valid_r;
        end
    end

    // Two-cycle ERROR tracking: holds off the pending address phase until the ERROR completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_hold_r <= 1'b0;
        end else if (err_first_s) begin
            err_hold_r <= 1'b1;
        end else if (err_second_s) begin
            err_hold_r <= 1'b0;
        end else begin
            err_hold_r <= err_hold_r;
        end
    end

    // Response register: one pulse per completed data phase, read data captured off the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_r <= 1'b0;
            rsp_write_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
        end else begin
            rsp_valid_r <= dp_done_s;
            if (dp_done_s) begin
                rsp_write_r <= dp_write_r;
                rsp_rdata_r <= dp_write_r ? 32'h0000_0000 : hrdata;
                rsp_err_r   <= hresp;
            end
        end
    end

    assign cmd_ready = cmd_ready_s;
    assign rsp_valid = rsp_valid_r;
    assign rsp_write = rsp_write_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;
    assign idle      = ~ap_valid_r & ~dp_valid_r;
    assign haddr     = ap_addr_r;
    assign htrans    = (ap_valid_r & ~err_hold_r) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign hwrite    = ap_write_r;
    assign hsize     = 3'b010;
    assign hburst    = 3'b000;
    assign hprot     = 4'b0011;
    assign hwdata    = dp_wdata_r;

endmodule

// File: tb/tb_ahb2_cmd_master.sv
// Directed bench for ahb2_cmd_master: small AHB memory slave, expected-response queue,
// and a monitor that pops and compares every rsp_valid pulse.
module tb_ahb2_cmd_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        idle;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    always #5 clk = ~clk;

    ahb2_cmd_master #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .idle(idle),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
        .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
        .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    // Memory slave: word i resets to 0xA5A5_0000 | byte address; ERROR data phases do not store.
    logic [31:0] mem [0:63];
    logic        s_dp_act;
    logic        s_dp_wr;
    logic [31:0] s_dp_addr;

    assign hrdata = (s_dp_act & ~s_dp_wr) ? mem[s_dp_addr[7:2]] : 32'h0000_0000;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA5A5_0000 | 32'(i * 4);
            s_dp_act  <= 1'b0;
            s_dp_wr   <= 1'b0;
            s_dp_addr <= 32'h0;
        end else if (hready) begin
            if (s_dp_act && s_dp_wr && !hresp) mem[s_dp_addr[7:2]] <= hwdata;
            s_dp_act  <= (htrans == 2'b10);
            s_dp_wr   <= hwrite;
            s_dp_addr <= haddr;
        end
    end

    typedef struct {
        logic        wr;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   rsp_cyc[$];
    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;
    int   rsp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic note_fail(input string name);
        total++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    function automatic void expect_rsp(input logic wr, input logic [31:0] rd, input logic err);
        exp_t e;
        e.wr    = wr;
        e.rdata = rd;
        e.err   = err;
        exp_q.push_back(e);
    endfunction

    // Monitor: compares each response pulse against the head of the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rsp_valid === 1'b1) begin
                rsp_cnt++;
                rsp_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    note_fail("rsp_unexpected");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_write", rsp_write, e.wr);
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err",   rsp_err,   e.err);
                end
            end
        end
    end

    task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        output int waits);
        waits     = 0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        #1;
        while (cmd_ready !== 1'b1 && waits < 50) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (cmd_ready !== 1'b1) note_fail("send_timeout");
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || idle !== 1'b1) && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0 || idle !== 1'b1) note_fail(name);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int sz;
        int base;
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
        hready = 1'b1; hresp = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_htrans", htrans, 2'b00);
        chk("rst_haddr", haddr, 32'h0);
        chk("rst_hwrite", hwrite, 1'b0);
        chk("rst_hwdata", hwdata, 32'h0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_rsp_write", rsp_write, 1'b0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_idle", idle, 1'b1);

        // 1: write then read back, with latency checks on the write
        expect_rsp(1'b1, 32'h0, 1'b0);
        send(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, w);
        #1;
        chk("t1_htrans", htrans, 2'b10);
        chk("t1_haddr", haddr, 32'h10);
        chk("t1_hwrite", hwrite, 1'b1);
        @(negedge clk); #1;
        chk("t1_rsp_early", rsp_valid, 1'b0);
        chk("t1_hwdata", hwdata, 32'hDEAD_BEEF);
        @(negedge clk); #1;
        chk("t1_rsp_t3", rsp_valid, 1'b1);
        expect_rsp(1'b0, 32'hDEAD_BEEF, 1'b0);
        send(1'b0, 32'h0000_0010, 32'h0, w);
        drain("t1_drain");

        // 2: four back-to-back writes
        for (int i = 0; i < 4; i++) begin
            expect_rsp(1'b1, 32'h0, 1'b0);
            send(1'b1, 32'(i * 4), 32'h1000_0000 + 32'(i), w);
            chk("t2_no_wait", w, 0);
            #1;
            chk("t2_htrans", htrans, 2'b10);
            chk("t2_haddr", haddr, 32'(i * 4));
        end
        drain("t2_drain");
        sz = rsp_cyc.size();
        chk("t2_rsp_consecutive", rsp_cyc[sz-1] - rsp_cyc[sz-4], 3);
        expect_rsp(1'b0, 32'h1000_0002, 1'b0);
        send(1'b0, 32'h0000_0008, 32'h0, w);
        drain("t2_rb_drain");

        // 3: wait states while a read is in data phase and a write waits in address phase
        expect_rsp(1'b0, 32'hA5A5_0020, 1'b0);
        send(1'b0, 32'h0000_0020, 32'h0, w);
        expect_rsp(1'b1, 32'h0, 1'b0);
        send(1'b1, 32'h0000_0024, 32'hCAFE_0024, w);
        hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_htrans", htrans, 2'b10);
            chk("t3_haddr", haddr, 32'h24);
            chk("t3_hwrite", hwrite, 1'b1);
            chk("t3_cmd_ready", cmd_ready, 1'b0);
            chk("t3_rsp_valid", rsp_valid, 1'b0);
            @(negedge clk);
        end
        hready = 1'b1;
        @(negedge clk); #1;
        chk("t3_rsp_after_hready", rsp_valid, 1'b1);
        chk("t3_rsp_rdata", rsp_rdata, 32'hA5A5_0020);
        drain("t3_drain");

        // 4: two-cycle ERROR on a write with a read pending behind it
        expect_rsp(1'b1, 32'h0, 1'b1);
        send(1'b1, 32'h0000_0040, 32'h1111_0040, w);
        expect_rsp(1'b0, 32'hA5A5_0044, 1'b0);
        send(1'b0, 32'h0000_0044, 32'h0, w);
        hresp = 1'b1; hready = 1'b0;
        #1;
        chk("t4_err1_htrans", htrans, 2'b10);
        @(negedge clk);
        hready = 1'b1;
        #1;
        chk("t4_err2_htrans", htrans, 2'b00);
        chk("t4_err2_cmd_ready", cmd_ready, 1'b0);
        @(negedge clk);
        hresp = 1'b0;
        #1;
        chk("t4_reissue_htrans", htrans, 2'b10);
        chk("t4_reissue_haddr", haddr, 32'h44);
        chk("t4_reissue_hwrite", hwrite, 1'b0);
        drain("t4_drain");
        expect_rsp(1'b0, 32'hA5A5_0040, 1'b0);
        send(1'b0, 32'h0000_0040, 32'h0, w);
        drain("t4_rb_drain");

        // Single-cycle ERROR (hready=1): completes with error, pending read is not cancelled
        expect_rsp(1'b1, 32'h0, 1'b1);
        send(1'b1, 32'h0000_0050, 32'h2222_0050, w);
        expect_rsp(1'b0, 32'hA5A5_0054, 1'b0);
        send(1'b0, 32'h0000_0054, 32'h0, w);
        hresp = 1'b1;
        #1;
        chk("viol_htrans", htrans, 2'b10);
        @(negedge clk);
        hresp = 1'b0;
        #1;
        chk("viol_ap_advanced", htrans, 2'b00);
        chk("viol_busy", idle, 1'b0);
        drain("viol_drain");

        // 6: unaligned address is forced to a word boundary
        expect_rsp(1'b1, 32'h0, 1'b0);
        send(1'b1, 32'h0000_0013, 32'h1234_5678, w);
        #1;
        chk("t6_haddr", haddr, 32'h10);
        chk("t6_hsize", hsize, 3'b010);
        chk("t6_hburst", hburst, 3'b000);
        chk("t6_hprot", hprot, 4'b0011);
        expect_rsp(1'b0, 32'h1234_5678, 1'b0);
        send(1'b0, 32'h0000_0010, 32'h0, w);
        drain("t6_drain");

        // 5: reset while a read stalls in data phase discards it silently
        send(1'b0, 32'h0000_0048, 32'h0, w);
        @(negedge clk);
        hready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; hready = 1'b1;
        #1;
        chk("t5_htrans", htrans, 2'b00);
        chk("t5_idle", idle, 1'b1);
        chk("t5_rsp_valid", rsp_valid, 1'b0);
        chk("t5_cmd_ready", cmd_ready, 1'b1);
        base = rsp_cnt;
        repeat (4) @(negedge clk);
        #1;
        chk("t5_no_rsp", rsp_cnt, base);

        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
